// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stage indices, redirect causes, default PC width.
package pipe_ctrl_pkg;

  localparam int unsigned STG_IF   = 0;
  localparam int unsigned STG_ID   = 1;
  localparam int unsigned STG_EX   = 2;
  localparam int unsigned STG_MEM  = 3;

  localparam int unsigned PC_W_DEF = 32;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_JMP,
    RD_BR,
    RD_EXC
  } redirect_cause_e;

endpackage

// File: rtl/redirect_flush_ctrl_if.sv
// Redirect/flush bundle between the pipeline (master) and the flush controller (slave).
interface redirect_flush_ctrl_if #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CNT_W      = 16
);

  logic                  stall;
  logic                  jmp;
  logic [PC_W-1:0]       jmp_target;
  logic                  br_mispredict;
  logic [PC_W-1:0]       br_target;
  logic                  exc;
  logic [PC_W-1:0]       exc_vector;
  logic                  cnt_clr;

  logic [NUM_STAGES-1:0] flush;
  logic                  redirect_valid;
  logic [PC_W-1:0]       redirect_pc;
  logic                  win_busy;
  logic [CNT_W-1:0]      cnt_jmp;
  logic [CNT_W-1:0]      cnt_br;
  logic [CNT_W-1:0]      cnt_exc;

  modport master (
    output stall, jmp, jmp_target, br_mispredict, br_target, exc, exc_vector, cnt_clr,
    input  flush, redirect_valid, redirect_pc, win_busy, cnt_jmp, cnt_br, cnt_exc
  );

  modport slave (
    input  stall, jmp, jmp_target, br_mispredict, br_target, exc, exc_vector, cnt_clr,
    output flush, redirect_valid, redirect_pc, win_busy, cnt_jmp, cnt_br, cnt_exc
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear wins over increment; hold at all-ones once reached.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/redirect_flush_ctrl.sv
// Control-hazard flush unit: picks the oldest redirect, kills younger stages,
// and opens a suppression window so squashed younger jmp/br cannot re-fire.
module redirect_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned JMP_STAGE  = STG_ID,
  parameter int unsigned BR_STAGE   = STG_EX,
  parameter int unsigned EXC_STAGE  = STG_MEM,
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  redirect_flush_ctrl_if.slave  bus
);

  localparam int unsigned WIN_W = $clog2(NUM_STAGES + 2);

  // Stage ordering must be strictly increasing and inside the flush vector.
  if (!((JMP_STAGE > STG_IF) && (JMP_STAGE < BR_STAGE) &&
        (BR_STAGE < EXC_STAGE) && (EXC_STAGE < NUM_STAGES))) begin : g_bad_stage_order
    $error("redirect_flush_ctrl: need 0 < JMP_STAGE < BR_STAGE < EXC_STAGE < NUM_STAGES");
  end

  logic [WIN_W-1:0]      win_cnt;
  logic                  sup;
  redirect_cause_e       cause;
  int unsigned           acc_stage;
  logic [PC_W-1:0]       acc_target;
  logic [NUM_STAGES-1:0] acc_mask;

  assign sup = (win_cnt != '0);

  // Oldest-first arbitration; exceptions bypass the suppression window.
  always_comb begin
    cause = RD_NONE;
    if (bus.exc) begin
      cause = RD_EXC;
    end else if (!sup && bus.br_mispredict) begin
      cause = RD_BR;
    end else if (!sup && bus.jmp) begin
      cause = RD_JMP;
    end
  end

  // Winner's resolving stage and redirect target.
  always_comb begin
    acc_stage  = 0;
    acc_target = '0;
    case (cause)
      RD_EXC: begin
        acc_stage  = EXC_STAGE;
        acc_target = bus.exc_vector;
      end
      RD_BR: begin
        acc_stage  = BR_STAGE;
        acc_target = bus.br_target;
      end
      RD_JMP: begin
        acc_stage  = JMP_STAGE;
        acc_target = bus.jmp_target;
      end
      default: begin
        acc_stage  = 0;
        acc_target = '0;
      end
    endcase
  end

  // Kill every stage younger than the resolving stage.
  always_comb begin
    acc_mask = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      acc_mask[i] = (i < acc_stage);
    end
  end

  assign bus.flush          = rst ? '0 : acc_mask;
  assign bus.redirect_valid = !rst && (cause != RD_NONE);
  assign bus.redirect_pc    = rst ? '0 : acc_target;
  assign bus.win_busy       = sup;

  // Window reloads on any acceptance, otherwise drains only on advancing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (cause != RD_NONE) begin
      win_cnt <= WIN_W'(acc_stage + 1);
    end else if (!bus.stall && sup) begin
      win_cnt <= win_cnt - WIN_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_jmp (
    .clk (clk),
    .rst (rst),
    .inc (cause == RD_JMP),
    .clr (bus.cnt_clr),
    .cnt (bus.cnt_jmp)
  );

  sat_counter #(.W(CNT_W)) u_cnt_br (
    .clk (clk),
    .rst (rst),
    .inc (cause == RD_BR),
    .clr (bus.cnt_clr),
    .cnt (bus.cnt_br)
  );

  sat_counter #(.W(CNT_W)) u_cnt_exc (
    .clk (clk),
    .rst (rst),
    .inc (cause == RD_EXC),
    .clr (bus.cnt_clr),
    .cnt (bus.cnt_exc)
  );

endmodule
